// File: rtl/sched_pkg.sv
// Shared types and default sizing for the process scheduler and its helpers.
package sched_pkg;

  localparam int unsigned DEF_NUM_PROC = 4;
  localparam int unsigned DEF_PC_W     = 32;
  localparam int unsigned DEF_QUANTUM  = 10;
  localparam int unsigned ID_W         = $clog2(DEF_NUM_PROC);

  typedef enum logic [1:0] {FREE, READY, BLOCKED} slot_state_t;
  typedef enum logic [1:0] {IDLE, RUN, SELECT, LOAD} sched_state_t;

endpackage

// File: rtl/process_scheduler_if.sv
// CPU-side bundle between the pipeline (master) and the process scheduler (slave).
interface process_scheduler_if #(
  parameter int unsigned PC_W = 32,
  parameter int unsigned ID_W = 2
);
  logic            instr_ret;
  logic [PC_W-1:0] pc;
  logic            io_req;
  logic            proc_end;
  logic            io_done;
  logic [ID_W-1:0] io_done_id;
  logic            create;
  logic [PC_W-1:0] create_pc;
  logic            create_ack;
  logic            create_full;
  logic            run_en;
  logic            pc_load;
  logic [PC_W-1:0] pc_next;
  logic [ID_W-1:0] cur_id;
  logic            ctx_switch;

  modport master (
    output instr_ret, pc, io_req, proc_end, io_done, io_done_id, create, create_pc,
    input  create_ack, create_full, run_en, pc_load, pc_next, cur_id, ctx_switch
  );

  modport slave (
    input  instr_ret, pc, io_req, proc_end, io_done, io_done_id, create, create_pc,
    output create_ack, create_full, run_en, pc_load, pc_next, cur_id, ctx_switch
  );
endinterface

// File: rtl/process_scheduler_rr_picker.sv
// Round-robin first-set search: scans mask from start upward, wrapping once.
module rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // N is a power of two, so IW-bit addition wraps naturally
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = start + IW'(i);
      if (!found && mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/process_scheduler.sv
// Round-robin time-slice scheduler: owns the process table and drives PC loads
// when a process ends, blocks on I/O or exhausts its quantum.
module process_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned NUM_PROC = DEF_NUM_PROC,
  parameter int unsigned PC_W     = DEF_PC_W,
  parameter int unsigned QUANTUM  = DEF_QUANTUM
) (
  input  logic                clock,
  input  logic                reset,
  process_scheduler_if.slave  sch
);

  localparam int unsigned SW = $clog2(NUM_PROC);
  localparam int unsigned CW = $clog2(QUANTUM + 1);

  sched_state_t    state, state_nxt;
  slot_state_t     slot_st     [NUM_PROC];
  slot_state_t     slot_st_nxt [NUM_PROC];
  logic [PC_W-1:0] saved_pc     [NUM_PROC];
  logic [PC_W-1:0] saved_pc_nxt [NUM_PROC];
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [SW-1:0]   cur_id, cur_id_nxt;
  logic [PC_W-1:0] pc_next, pc_next_nxt;
  logic            run_en, run_en_nxt;
  logic            pc_load, pc_load_nxt;
  logic            ctx_switch, ctx_nxt;
  logic            create_ack, ack_nxt;

  logic [NUM_PROC-1:0] ready_mask, free_mask;
  logic                pick_found, free_found;
  logic [SW-1:0]       pick_id, free_id;

  always_comb begin
    for (int unsigned i = 0; i < NUM_PROC; i++) begin
      ready_mask[i] = (slot_st[i] == READY);
      free_mask[i]  = (slot_st[i] == FREE);
    end
  end

  // Lowest-index free slot for process creation
  always_comb begin
    free_found = 1'b0;
    free_id    = '0;
    for (int i = int'(NUM_PROC) - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        free_found = 1'b1;
        free_id    = SW'(i);
      end
    end
  end

  // Starting one past the running slot makes the current slot the last candidate
  rr_picker #(.N(NUM_PROC), .IW(SW)) u_pick (
    .mask  (ready_mask),
    .start (cur_id + SW'(1)),
    .found (pick_found),
    .idx   (pick_id)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cur_id_nxt   = cur_id;
    pc_next_nxt  = pc_next;
    pc_load_nxt  = 1'b0;
    ctx_nxt      = 1'b0;
    ack_nxt      = 1'b0;
    slot_st_nxt  = slot_st;
    saved_pc_nxt = saved_pc;

    unique case (state)
      IDLE: if (|ready_mask) state_nxt = SELECT;
      SELECT: begin
        if (pick_found) begin
          state_nxt   = LOAD;
          pc_load_nxt = 1'b1;
          pc_next_nxt = saved_pc[pick_id];
          cur_id_nxt  = pick_id;
          ctx_nxt     = (pick_id != cur_id);
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD: state_nxt = RUN;
      RUN: begin
        if (sch.instr_ret) begin
          if (sch.proc_end) begin
            slot_st_nxt[cur_id] = FREE;
            state_nxt           = SELECT;
          end else if (sch.io_req) begin
            saved_pc_nxt[cur_id] = sch.pc + PC_W'(1);
            slot_st_nxt[cur_id]  = BLOCKED;
            state_nxt            = SELECT;
          end else if (cnt == CW'(QUANTUM - 1)) begin
            saved_pc_nxt[cur_id] = sch.pc + PC_W'(1);
            state_nxt            = SELECT;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
          if (state_nxt != RUN) cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Unblock sees the post-retire table so a same-cycle block+unblock ends READY
    if (sch.io_done && slot_st_nxt[sch.io_done_id] == BLOCKED)
      slot_st_nxt[sch.io_done_id] = READY;

    // Creation only targets slots already FREE before this edge
    if (sch.create && free_found) begin
      slot_st_nxt[free_id]  = READY;
      saved_pc_nxt[free_id] = sch.create_pc;
      ack_nxt               = 1'b1;
    end

    run_en_nxt = (state_nxt == RUN);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_PROC; i++) begin
        slot_st[i]  <= FREE;
        saved_pc[i] <= '0;
      end
      cnt        <= '0;
      cur_id     <= '0;
      pc_next    <= '0;
      run_en     <= 1'b0;
      pc_load    <= 1'b0;
      ctx_switch <= 1'b0;
      create_ack <= 1'b0;
    end else begin
      slot_st    <= slot_st_nxt;
      saved_pc   <= saved_pc_nxt;
      cnt        <= cnt_nxt;
      cur_id     <= cur_id_nxt;
      pc_next    <= pc_next_nxt;
      run_en     <= run_en_nxt;
      pc_load    <= pc_load_nxt;
      ctx_switch <= ctx_nxt;
      create_ack <= ack_nxt;
    end
  end

  assign sch.create_ack  = create_ack;
  assign sch.create_full = ~|free_mask;
  assign sch.run_en      = run_en;
  assign sch.pc_load     = pc_load;
  assign sch.pc_next     = pc_next;
  assign sch.cur_id      = cur_id;
  assign sch.ctx_switch  = ctx_switch;

endmodule
